perf_event_counter: RTL and testbench

- Hardware performance-monitor unit for the core.
- Samples the core's event bundle and the retire strobe every cycle.
- Keeps fixed cycle and instret counters plus N programmable event counters, each steered by a CSR-written event selector.
- Sits beside the CSR file, which forwards machine-mode counter CSR accesses to it over a request/ack handshake.

---
 rtl/perf_event_counter.sv | 164 ++++++++++++++++
 tb/tb_perf_event_counter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_counter.sv
// Machine-mode performance counters: mcycle, minstret and N_HPM event counters behind a CSR
// request/ack port. Define PERF_OVF_IRQ_EN to add sticky overflow bits (mhpmovf) and ovf_irq_o.
// events_i bit order: load, store, unaligned, arithmetic, trap, interrupt, cond_br, uncond_br, br.
module perf_event_counter #(
  parameter int unsigned N_HPM = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [8:0]  events_i,
  input  logic        retire_i,
  input  logic        csr_req_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_ack_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  output logic        ovf_irq_o
);

  // Counter slots are indexed by CSR offset: 0 cycle, 1 unused, 2 instret, 3+i hpm i.
  localparam int unsigned NC = N_HPM + 3;
  localparam logic [31:0] ImplMask = 32'(((64'd1 << NC) - 64'd1) & ~64'd2);

  logic [CNT_W-1:0] cnt_q [NC];
  logic [CNT_W-1:0] cnt_d [NC];
  logic [3:0]       sel_q [N_HPM];
  logic [3:0]       sel_d [N_HPM];
  logic [31:0]      inh_q, inh_d;
  logic             retire_q;
  logic [N_HPM-1:0] hit_q, hit_d;
  logic             ack_q, err_q;
  logic [31:0]      rdata_q;

  logic [4:0]    idx;
  logic          cnt_ok, is_lo, is_hi, is_evt, is_inh, is_ovf, legal, wr;
  logic [31:0]   rd_data;
  logic [NC-1:0] inc_v, wr_lo, wr_hi;
  logic [15:0]   ev_ext;

`ifdef PERF_OVF_IRQ_EN
  logic [31:0] ovf_q, ovf_d;
  logic        irq_q;
`endif

  always_comb begin
    idx    = csr_addr_i[4:0];
    cnt_ok = 1'b0;
    for (int j = 0; j < NC; j++) begin
      if (idx == 5'(j) && j != 1) cnt_ok = 1'b1;
    end
    is_lo  = (csr_addr_i[11:5] == 7'h58) && cnt_ok;
    is_hi  = (csr_addr_i[11:5] == 7'h5C) && cnt_ok;
    is_evt = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3) && cnt_ok;
    is_inh = (csr_addr_i == 12'h320);
`ifdef PERF_OVF_IRQ_EN
    is_ovf = (csr_addr_i == 12'h7C0);
`else
    is_ovf = 1'b0;
`endif
    legal = is_lo || is_hi || is_evt || is_inh || is_ovf;
    wr    = csr_req_i && csr_we_i && legal;

    rd_data = '0;
    for (int j = 0; j < NC; j++) begin
      if (idx == 5'(j)) begin
        if (is_lo) rd_data = cnt_q[j][31:0];
        if (is_hi) rd_data = 32'(cnt_q[j][CNT_W-1:32]);
      end
    end
    for (int i = 0; i < N_HPM; i++) begin
      if (is_evt && idx == 5'(3 + i)) rd_data = {28'd0, sel_q[i]};
    end
    if (is_inh) rd_data = inh_q;
`ifdef PERF_OVF_IRQ_EN
    if (is_ovf) rd_data = ovf_q;
`endif
  end

  // Selection happens at the sampling stage, so a selector write only affects later samples.
  assign ev_ext = {6'd0, events_i, 1'b0};

  always_comb begin
    for (int i = 0; i < N_HPM; i++) begin
      hit_d[i] = ev_ext[sel_q[i]];
      sel_d[i] = (wr && is_evt && idx == 5'(3 + i)) ? csr_wdata_i[3:0] : sel_q[i];
    end
    inh_d = (wr && is_inh) ? (csr_wdata_i & ImplMask) : inh_q;
  end

  always_comb begin
    inc_v    = '0;
    inc_v[0] = 1'b1;
    inc_v[2] = retire_q;
    for (int i = 0; i < N_HPM; i++) inc_v[3 + i] = hit_q[i];
    inc_v = inc_v & ~inh_q[NC-1:0];
    for (int j = 0; j < NC; j++) begin
      wr_lo[j] = wr && is_lo && (idx == 5'(j));
      wr_hi[j] = wr && is_hi && (idx == 5'(j));
      cnt_d[j] = cnt_q[j] + CNT_W'(inc_v[j]);
      // A CSR write replaces one half and drops this cycle's increment entirely.
      if (wr_lo[j]) begin
        cnt_d[j]       = cnt_q[j];
        cnt_d[j][31:0] = csr_wdata_i;
      end
      if (wr_hi[j]) begin
        cnt_d[j]             = cnt_q[j];
        cnt_d[j][CNT_W-1:32] = csr_wdata_i[CNT_W-33:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NC; j++) cnt_q[j] <= '0;
      for (int i = 0; i < N_HPM; i++) sel_q[i] <= '0;
      inh_q    <= '0;
      retire_q <= 1'b0;
      hit_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int j = 0; j < NC; j++) cnt_q[j] <= cnt_d[j];
      for (int i = 0; i < N_HPM; i++) sel_q[i] <= sel_d[i];
      inh_q    <= inh_d;
      retire_q <= retire_i;
      hit_q    <= hit_d;
      ack_q    <= csr_req_i;
      err_q    <= csr_req_i && !legal;
      rdata_q  <= (csr_req_i && legal) ? rd_data : 32'd0;
    end
  end

`ifdef PERF_OVF_IRQ_EN
  always_comb begin
    ovf_d = ovf_q;
    if (wr && is_ovf) ovf_d = ovf_q & ~csr_wdata_i;
    for (int j = 0; j < NC; j++) begin
      if (inc_v[j] && (&cnt_q[j]) && !wr_lo[j] && !wr_hi[j]) ovf_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_d;
    end
  end

  assign ovf_irq_o = irq_q;
`else
  assign ovf_irq_o = 1'b0;
`endif

  assign csr_ack_o   = ack_q;
  assign csr_err_o   = err_q;
  assign csr_rdata_o = rdata_q;

endmodule

// File: tb/tb_perf_event_counter.sv
// Self-checking bench for perf_event_counter: directed table, hand sequences and random traffic
// compared against an architectural model of the counter CSRs.
module tb_perf_event_counter;

  localparam int unsigned N_HPM = 4;
  localparam int unsigned CNT_W = 64;
  localparam int NC = N_HPM + 3;
  localparam longint unsigned Mask = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF :
                                     ((64'd1 << CNT_W) - 64'd1);

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [8:0]  events_i = '0;
  logic        retire_i = 1'b0;
  logic        csr_req_i = 1'b0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic        csr_ack_o, csr_err_o, ovf_irq_o;
  logic [31:0] csr_rdata_o;

  perf_event_counter #(.N_HPM(N_HPM), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .events_i    (events_i),
    .retire_i    (retire_i),
    .csr_req_i   (csr_req_i),
    .csr_we_i    (csr_we_i),
    .csr_addr_i  (csr_addr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_ack_o   (csr_ack_o),
    .csr_rdata_o (csr_rdata_o),
    .csr_err_o   (csr_err_o),
    .ovf_irq_o   (ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;

  // Architectural model state.
  longint unsigned  m_cnt [NC];
  logic [3:0]       m_sel [N_HPM];
  logic [31:0]      m_inh, m_ovf, m_impl;
  logic             m_pend_ret;
  logic [N_HPM-1:0] m_pend_hit;
  logic             exp_ack, exp_err, exp_irq;
  logic [31:0]      exp_rdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_cnt[k] = 0;
    for (int i = 0; i < N_HPM; i++) m_sel[i] = 0;
    m_inh = 0; m_ovf = 0; m_pend_ret = 0; m_pend_hit = 0;
    m_impl = 32'h1;
    for (int k = 2; k < NC; k++) m_impl[k] = 1'b1;
  endtask

  task automatic model_read(input logic [11:0] a, output logic ok, output logic [31:0] v);
    ok = 1'b0; v = 32'd0;
    if (a == 12'h320) begin
      ok = 1'b1; v = m_inh;
    end else if (a >= 12'h323 && a < 12'h323 + 12'(N_HPM)) begin
      ok = 1'b1; v = {28'd0, m_sel[int'(a - 12'h323)]};
    end else if (a >= 12'hB00 && a < 12'hB00 + 12'(NC) && a != 12'hB01) begin
      ok = 1'b1; v = m_cnt[int'(a - 12'hB00)][31:0];
    end else if (a >= 12'hB80 && a < 12'hB80 + 12'(NC) && a != 12'hB81) begin
      ok = 1'b1; v = m_cnt[int'(a - 12'hB80)][63:32];
    end
`ifdef PERF_OVF_IRQ_EN
    else if (a == 12'h7C0) begin
      ok = 1'b1; v = m_ovf;
    end
`endif
  endtask

  // One clock edge of architectural behaviour: respond from pre-edge state, then update.
  task automatic model_edge(input logic [8:0] ev, input logic ret, input logic req,
                            input logic we, input logic [11:0] a, input logic [31:0] wd);
    logic ok;
    logic [31:0] v, wraps;
    longint unsigned nxt [NC];
    longint unsigned inc;
    int k;
    model_read(a, ok, v);
    exp_ack   = req;
    exp_err   = req && !ok;
    exp_rdata = (req && ok) ? v : 32'd0;
    wraps = 0;
    for (int j = 0; j < NC; j++) begin
      inc = 0;
      if (j == 0) inc = 1;
      else if (j == 2) inc = longint'(m_pend_ret);
      else if (j >= 3) inc = longint'(m_pend_hit[j-3]);
      if (m_inh[j]) inc = 0;
      nxt[j] = (m_cnt[j] + inc) & Mask;
      if (inc != 0 && m_cnt[j] == Mask) wraps[j] = 1'b1;
    end
    m_pend_ret = ret;
    for (int i = 0; i < N_HPM; i++)
      m_pend_hit[i] = (m_sel[i] >= 1 && m_sel[i] <= 9) ? ev[int'(m_sel[i]) - 1] : 1'b0;
    if (req && ok && we) begin
      if (a >= 12'hB00 && a < 12'hB00 + 12'(NC)) begin
        k = int'(a - 12'hB00);
        nxt[k] = (m_cnt[k] & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
        wraps[k] = 1'b0;
      end else if (a >= 12'hB80 && a < 12'hB80 + 12'(NC)) begin
        k = int'(a - 12'hB80);
        nxt[k] = ((64'(wd) << 32) & Mask) | (m_cnt[k] & 64'hFFFF_FFFF);
        wraps[k] = 1'b0;
      end else if (a == 12'h320) begin
        m_inh = wd & m_impl;
      end else if (a >= 12'h323 && a < 12'h323 + 12'(N_HPM)) begin
        m_sel[int'(a - 12'h323)] = wd[3:0];
      end else if (a == 12'h7C0) begin
        m_ovf = m_ovf & ~wd;
      end
    end
    for (int j = 0; j < NC; j++) m_cnt[j] = nxt[j];
`ifdef PERF_OVF_IRQ_EN
    m_ovf   = m_ovf | wraps;
    exp_irq = |m_ovf;
`else
    exp_irq = 1'b0;
`endif
  endtask

  // Called just after a rising edge; drives inputs, advances one edge, compares.
  task automatic step(input logic [8:0] ev, input logic ret, input logic req, input logic we,
                      input logic [11:0] a, input logic [31:0] wd, output logic [31:0] rd);
    events_i = ev; retire_i = ret; csr_req_i = req; csr_we_i = we;
    csr_addr_i = a; csr_wdata_i = wd;
    @(posedge clk_i);
    model_edge(ev, ret, req, we, a, wd);
    #1;
    chk("ack", 32'(csr_ack_o), 32'(exp_ack));
    chk("err", 32'(csr_err_o), 32'(exp_err));
    if (exp_ack) chk("rdata", csr_rdata_o, exp_rdata);
    chk("ovf_irq", 32'(ovf_irq_o), 32'(exp_irq));
    rd = csr_rdata_o;
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) step(9'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'd0, rd);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    step(9'd0, 1'b0, 1'b1, 1'b1, a, wd, rd);
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] rd);
    step(9'd0, 1'b0, 1'b1, 1'b0, a, 32'd0, rd);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  logic [11:0] rnd_addr [20];

  initial begin
    logic [31:0] rd, v1, v2, v3;
    tbl[0] = '{12'h555, 1'b0, 1'b1, 32'd0};
    tbl[1] = '{12'h321, 1'b1, 1'b1, 32'd0};
    tbl[2] = '{12'hB01, 1'b0, 1'b1, 32'd0};
    tbl[3] = '{12'hB81, 1'b1, 1'b1, 32'd0};
    tbl[4] = '{12'h327, 1'b0, 1'b1, 32'd0};
    tbl[5] = '{12'hB07, 1'b1, 1'b1, 32'd0};
    tbl[6] = '{12'h320, 1'b0, 1'b0, 32'd0};
    tbl[7] = '{12'h324, 1'b0, 1'b0, 32'd0};
    tbl[8] = '{12'h326, 1'b0, 1'b0, 32'd0};
`ifdef PERF_OVF_IRQ_EN
    tbl[9] = '{12'h7C0, 1'b0, 1'b0, 32'd0};
`else
    tbl[9] = '{12'h7C0, 1'b0, 1'b1, 32'd0};
`endif
    rnd_addr = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                 12'hB83, 12'hB86, 12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'h7C0,
                 12'h555, 12'hB01, 12'h323, 12'hB03};

    model_reset();
    repeat (3) @(posedge clk_i);
    csr_req_i = 1'b1;
    @(posedge clk_i); #1;
    chk("reset_ack", 32'(csr_ack_o), 32'd0);
    chk("reset_err", 32'(csr_err_o), 32'd0);
    chk("reset_rdata", csr_rdata_o, 32'd0);
    chk("reset_irq", 32'(ovf_irq_o), 32'd0);
    csr_req_i = 1'b0;
    rst_ni = 1'b1;

    // Two counting edges after release, then read mcycle.
    idle(2);
    csr_rd(12'hB00, rd);
    chk("mcycle_after_reset", rd, 32'd2);

    // Decode table, issued back to back.
    for (int i = 0; i < 10; i++) begin
      step(9'd0, 1'b0, 1'b1, tbl[i].we, tbl[i].addr, 32'hFFFF_FFFF, rd);
      chk("tbl_err", 32'(csr_err_o), 32'(tbl[i].exp_err));
      chk("tbl_rdata", rd, tbl[i].exp_rdata);
    end

    // Store counting on hpm3.
    csr_wr(12'h323, 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(9'b0_0000_0010, 1'b0, 1'b0, 1'b0, 12'h0, 32'd0, rd);
    end
    idle(3);
    csr_rd(12'hB03, rd); chk("hpm3_store", rd, 32'd5);
    csr_rd(12'hB04, rd); chk("hpm4_idle", rd, 32'd0);
    csr_rd(12'hB06, rd); chk("hpm6_idle", rd, 32'd0);

    // Inhibit mcycle.
    csr_wr(12'h320, 32'h1);
    idle(10);
    csr_rd(12'hB00, v1);
    idle(3);
    csr_rd(12'hB00, v2);
    chk("inhibit_hold", v2, v1);
    csr_wr(12'h320, 32'h0);
    idle(2);
    csr_rd(12'hB00, v3);
    chk("inhibit_resume", 32'(v3 > v1), 32'd1);

    // Wrap hpm3 with a single load.
    csr_wr(12'h323, 32'd1);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    step(9'b0_0000_0001, 1'b0, 1'b0, 1'b0, 12'h0, 32'd0, rd);
    idle(1);
    csr_rd(12'hB03, rd); chk("wrap_lo", rd, 32'd0);
    csr_rd(12'hB83, rd); chk("wrap_hi", rd, 32'd0);
`ifdef PERF_OVF_IRQ_EN
    chk("wrap_irq", 32'(ovf_irq_o), 32'd1);
    csr_rd(12'h7C0, rd); chk("mhpmovf_bit3", rd & 32'h8, 32'h8);
    csr_wr(12'h7C0, 32'h8);
    csr_rd(12'h7C0, rd); chk("mhpmovf_clear", rd, 32'h0);
    chk("irq_clear", 32'(ovf_irq_o), 32'd0);
`endif

    // Write collides with a pending load increment.
    step(9'b0_0000_0001, 1'b0, 1'b0, 1'b0, 12'h0, 32'd0, rd);
    csr_wr(12'hB03, 32'h0000_1234);
    idle(1);
    csr_rd(12'hB03, rd); chk("write_beats_inc", rd, 32'h0000_1234);

    // Illegal read and back-to-back acks.
    csr_rd(12'h555, rd);
    chk("illegal_err", 32'(csr_err_o), 32'd1);
    chk("illegal_rdata", rd, 32'd0);
    csr_rd(12'hB02, rd);
    chk("b2b_ack", 32'(csr_ack_o), 32'd1);

    // Reset during an access drops the ack.
    csr_req_i = 1'b1; csr_we_i = 1'b0; csr_addr_i = 12'hB00;
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_mid_ack", 32'(csr_ack_o), 32'd0);
    chk("rst_mid_rdata", csr_rdata_o, 32'd0);
    csr_req_i = 1'b0;
    rst_ni = 1'b1;
    model_reset();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        req, we;
      logic [31:0] wd;
      req = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: wd = 32'hFFFF_FFFF;
        1: wd = 32'hFFFF_FFFE;
        2: wd = $urandom_range(0, 15);
        default: wd = $urandom;
      endcase
      step(9'($urandom), 1'($urandom), req, we, rnd_addr[$urandom_range(0, 19)], wd, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
